// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline widths, MEM-stage FSM encoding and the
// data-memory request payload.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Memory-interface FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Request held stable towards data memory while an access is outstanding
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_if_ctrl.sv
// dmem_if_ctrl: data-memory handshake controller for the MEM stage.
// Owns the IDLE/WAIT FSM, the registered request (req/we/addr/wdata), the
// mem_err pulse and, with MEM_STAGE_TIMEOUT_EN defined, an ack watchdog.
// Ports:
//   clk, rst                 clock, async active-low reset
//   ex_m2reg, ex_wmem        access type from EX
//   ex_aluR, ex_inB          byte address and store data
//   dmem_ack                 access complete (honoured only in WAIT)
//   dmem_req/we/addr/wdata   registered memory request
//   mem_err                  registered one-cycle error pulse
//   mem_stall                combinational upstream freeze
//   accept_c                 combinational: MEM/WB loads from EX this cycle
module dmem_if_ctrl
  import mips_pkg::*;
`ifdef MEM_STAGE_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 15
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [DATA_W-1:0] ex_aluR,
  input  logic [DATA_W-1:0] ex_inB,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_err,
  output logic              mem_stall,
  output logic              accept_c
);

  logic [0:0] state_q, state_d;
  dmem_req_t  req_q, req_d;
  logic       err_d;
  logic       access_c, misaligned_c, timeout_c;

  assign access_c     = ex_m2reg | ex_wmem;
  assign misaligned_c = access_c & (ex_aluR[1:0] != 2'b00);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT-th WAIT cycle without an ack; an ack that cycle wins
  assign timeout_c = (state_q == WAIT) & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Held at zero in IDLE so it is clear on entry to WAIT
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (!dmem_ack)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, request capture, stall and accept decode
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    err_d     = 1'b0;
    mem_stall = 1'b0;
    accept_c  = 1'b0;
    if (state_q == IDLE) begin
      if (!access_c) begin
        accept_c = 1'b1;
      end else if (misaligned_c) begin
        err_d = 1'b1;
      end else begin
        state_d   = WAIT;
        req_d     = '{we: ex_wmem, addr: ex_aluR, wdata: ex_inB};
        mem_stall = 1'b1;
      end
    end else begin
      if (dmem_ack) begin
        state_d  = IDLE;
        accept_c = 1'b1;
      end else if (timeout_c) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        mem_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mem_err <= err_d;
    end
  end

  // Request is live exactly while the FSM sits in WAIT
  assign dmem_req   = (state_q == WAIT);
  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Issues loads/stores through dmem_if_ctrl, stalls upstream while an access
// is outstanding, passes the branch decision to fetch and registers MEM/WB.
// Optional feature: MEM_STAGE_TIMEOUT_EN enables a TIMEOUT-cycle ack watchdog.
// Ports:
//   clk, rst                          clock, async active-low reset
//   ex_*                              EX/MEM register contents
//   EXE_ins_type, EXE_ins_number      debug tags in
//   dmem_req/we/addr/wdata            registered data-memory request
//   dmem_ack, dmem_rdata              data-memory response
//   mem_stall                         combinational upstream freeze
//   mem_pcsrc, mem_target             combinational branch pass-through
//   mem_err                           registered misalign/timeout pulse
//   wb_*, MEM_ins_*                   registered MEM/WB values
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [DATA_W-1:0] ex_aluR,
  input  logic [DATA_W-1:0] ex_inB,
  input  logic [REG_W-1:0]  ex_destR,
  input  logic              ex_branch,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [3:0]        EXE_ins_type,
  input  logic [3:0]        EXE_ins_number,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              mem_pcsrc,
  output logic [DATA_W-1:0] mem_target,
  output logic              mem_err,
  output logic              wb_wreg,
  output logic              wb_m2reg,
  output logic [DATA_W-1:0] wb_aluR,
  output logic [DATA_W-1:0] wb_mdata,
  output logic [REG_W-1:0]  wb_destR,
  output logic [3:0]        MEM_ins_type,
  output logic [3:0]        MEM_ins_number
);

  logic accept_c;

  // A zero watchdog period is meaningless; this marker makes such a build visible
  if (TIMEOUT == 0) begin : g_timeout_zero_unsupported
  end

  dmem_if_ctrl
`ifdef MEM_STAGE_TIMEOUT_EN
    #(.TIMEOUT(TIMEOUT))
`endif
  u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ex_m2reg   (ex_m2reg),
    .ex_wmem    (ex_wmem),
    .ex_aluR    (ex_aluR),
    .ex_inB     (ex_inB),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .mem_err    (mem_err),
    .mem_stall  (mem_stall),
    .accept_c   (accept_c)
  );

  assign mem_pcsrc  = ex_branch;
  assign mem_target = ex_pc;

  // MEM/WB register: load from EX on accept, otherwise insert a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wreg        <= 1'b0;
      wb_m2reg       <= 1'b0;
      wb_aluR        <= '0;
      wb_mdata       <= '0;
      wb_destR       <= '0;
      MEM_ins_type   <= '0;
      MEM_ins_number <= '0;
    end else if (accept_c) begin
      wb_wreg        <= ex_wreg;
      wb_m2reg       <= ex_m2reg;
      wb_aluR        <= ex_aluR;
      wb_destR       <= ex_destR;
      MEM_ins_type   <= EXE_ins_type;
      MEM_ins_number <= EXE_ins_number;
      // Accept of a load only happens on its ack, so rdata is valid here
      if (ex_m2reg) wb_mdata <= dmem_rdata;
    end else begin
      wb_wreg        <= 1'b0;
      wb_m2reg       <= 1'b0;
      MEM_ins_type   <= '0;
      MEM_ins_number <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, mem_pcsrc, mem_err;
  logic [31:0] mem_target;
  logic        wb_wreg, wb_m2reg;
  logic [31:0] wb_aluR, wb_mdata;
  logic [4:0]  wb_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_branch(ex_branch), .ex_pc(ex_pc),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_pcsrc(mem_pcsrc), .mem_target(mem_target),
    .mem_err(mem_err),
    .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_aluR(wb_aluR),
    .wb_mdata(wb_mdata), .wb_destR(wb_destR),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg, m2reg, wmem, br;
    logic [31:0] alu, inb, pc;
    logic [4:0]  dest;
    logic [3:0]  ty, nu;
  } ins_t;

  typedef struct {
    ins_t        i;
    logic        e_err, e_wreg, e_m2reg, e_pcsrc, chk_alu;
    logic [31:0] e_alu, e_target;
    logic [4:0]  e_dest;
    logic [3:0]  e_ty, e_nu;
  } vec_t;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_mdata = 32'h0;   // model: last loaded data word

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic wreg, input logic m2reg, input logic wmem,
                              input logic [31:0] alu, input logic [31:0] inb,
                              input logic [4:0] dest, input logic br, input logic [31:0] pc,
                              input logic [3:0] ty, input logic [3:0] nu);
    ins_t x;
    x.wreg = wreg; x.m2reg = m2reg; x.wmem = wmem; x.alu = alu; x.inb = inb;
    x.dest = dest; x.br = br; x.pc = pc; x.ty = ty; x.nu = nu;
    return x;
  endfunction

  task automatic drive(input ins_t x);
    ex_wreg = x.wreg; ex_m2reg = x.m2reg; ex_wmem = x.wmem; ex_aluR = x.alu;
    ex_inB = x.inb; ex_destR = x.dest; ex_branch = x.br; ex_pc = x.pc;
    EXE_ins_type = x.ty; EXE_ins_number = x.nu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".wb_wreg"},  32'(wb_wreg),  32'h0);
    chk({tag, ".wb_m2reg"}, 32'(wb_m2reg), 32'h0);
    chk({tag, ".tags"},     32'({MEM_ins_type, MEM_ins_number}), 32'h0);
    chk({tag, ".wb_mdata"}, wb_mdata, exp_mdata);
  endtask

  task automatic chk_accept(input string tag, input ins_t x);
    chk({tag, ".wb_wreg"},  32'(wb_wreg),  32'(x.wreg));
    chk({tag, ".wb_m2reg"}, 32'(wb_m2reg), 32'(x.m2reg));
    chk({tag, ".wb_aluR"},  wb_aluR,       x.alu);
    chk({tag, ".wb_destR"}, 32'(wb_destR), 32'(x.dest));
    chk({tag, ".tags"},     32'({MEM_ins_type, MEM_ins_number}), 32'({x.ty, x.nu}));
    chk({tag, ".wb_mdata"}, wb_mdata,      exp_mdata);
  endtask

  // One IDLE cycle: non-access or misaligned instruction, stray ack allowed
  task automatic run_single(input string tag, input ins_t x, input logic noise);
    logic bad;
    bad = (x.m2reg | x.wmem) && (x.alu[1:0] != 2'b00);
    drive(x);
    dmem_ack = noise; dmem_rdata = $urandom;
    #4;
    chk({tag, ".stall"},  32'(mem_stall), 32'h0);
    chk({tag, ".pcsrc"},  32'(mem_pcsrc), 32'(x.br));
    chk({tag, ".target"}, mem_target,     x.pc);
    chk({tag, ".req"},    32'(dmem_req),  32'h0);
    tick();
    dmem_ack = 1'b0;
    chk({tag, ".err"}, 32'(mem_err), 32'(bad));
    chk({tag, ".req1"}, 32'(dmem_req), 32'h0);
    if (bad) chk_bubble(tag);
    else     chk_accept(tag, x);
  endtask

  // Aligned access acked on WAIT cycle n (n >= 1)
  task automatic run_access(input string tag, input ins_t x, input int n,
                            input logic [31:0] rdata, input logic noise);
    drive(x);
    dmem_ack = noise; dmem_rdata = $urandom;
    #4;
    chk({tag, ".stall0"}, 32'(mem_stall), 32'h1);
    chk({tag, ".req0"},   32'(dmem_req),  32'h0);
    tick();
    dmem_ack = 1'b0;
    chk({tag, ".req"},   32'(dmem_req), 32'h1);
    chk({tag, ".we"},    32'(dmem_we),  32'(x.wmem));
    chk({tag, ".addr"},  dmem_addr,     x.alu);
    chk({tag, ".wdata"}, dmem_wdata,    x.inb);
    chk({tag, ".err0"},  32'(mem_err),  32'h0);
    chk_bubble({tag, ".b0"});
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      #4;
      chk({tag, ".stall"}, 32'(mem_stall), 32'(k != n));
      chk({tag, ".waddr"}, dmem_addr, x.alu);
      tick();
      dmem_ack = 1'b0;
      if (k < n) begin
        chk({tag, ".reqw"}, 32'(dmem_req), 32'h1);
        chk_bubble({tag, ".bw"});
      end
    end
    if (x.m2reg) exp_mdata = rdata;
    chk({tag, ".reqd"}, 32'(dmem_req), 32'h0);
    chk({tag, ".errd"}, 32'(mem_err),  32'h0);
    chk_accept({tag, ".done"}, x);
  endtask

  vec_t tbl[6];
  ins_t nop, x;

  initial begin
    nop = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 4'h0, 4'h0);
    tbl[0] = '{i: mk(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0, 4'h1, 4'h2),
               e_err: 1'b0, e_wreg: 1'b1, e_m2reg: 1'b0, e_pcsrc: 1'b0, chk_alu: 1'b1,
               e_alu: 32'h1234, e_target: 32'h0, e_dest: 5'd5, e_ty: 4'h1, e_nu: 4'h2};
    tbl[1] = '{i: mk(1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 5'd0, 1'b1, 32'h100, 4'h3, 4'h4),
               e_err: 1'b0, e_wreg: 1'b0, e_m2reg: 1'b0, e_pcsrc: 1'b1, chk_alu: 1'b1,
               e_alu: 32'h8, e_target: 32'h100, e_dest: 5'd0, e_ty: 4'h3, e_nu: 4'h4};
    tbl[2] = '{i: mk(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd7, 1'b0, 32'h44, 4'h5, 4'h6),
               e_err: 1'b1, e_wreg: 1'b0, e_m2reg: 1'b0, e_pcsrc: 1'b0, chk_alu: 1'b0,
               e_alu: 32'h0, e_target: 32'h44, e_dest: 5'd0, e_ty: 4'h0, e_nu: 4'h0};
    tbl[3] = '{i: mk(1'b0, 1'b0, 1'b1, 32'h81, 32'h11, 5'd0, 1'b0, 32'h48, 4'h7, 4'h8),
               e_err: 1'b1, e_wreg: 1'b0, e_m2reg: 1'b0, e_pcsrc: 1'b0, chk_alu: 1'b0,
               e_alu: 32'h0, e_target: 32'h48, e_dest: 5'd0, e_ty: 4'h0, e_nu: 4'h0};
    tbl[4] = '{i: mk(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd31, 1'b0, 32'h4C, 4'hF, 4'hF),
               e_err: 1'b0, e_wreg: 1'b1, e_m2reg: 1'b0, e_pcsrc: 1'b0, chk_alu: 1'b1,
               e_alu: 32'hFFFFFFFF, e_target: 32'h4C, e_dest: 5'd31, e_ty: 4'hF, e_nu: 4'hF};
    tbl[5] = '{i: mk(1'b1, 1'b1, 1'b0, 32'h43, 32'h0, 5'd3, 1'b0, 32'h50, 4'h9, 4'hA),
               e_err: 1'b1, e_wreg: 1'b0, e_m2reg: 1'b0, e_pcsrc: 1'b0, chk_alu: 1'b0,
               e_alu: 32'h0, e_target: 32'h50, e_dest: 5'd0, e_ty: 4'h0, e_nu: 4'h0};

    // Reset state
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(nop);
    #2;
    chk("rst.req",   32'(dmem_req), 32'h0);
    chk("rst.we",    32'(dmem_we),  32'h0);
    chk("rst.addr",  dmem_addr,     32'h0);
    chk("rst.wdata", dmem_wdata,    32'h0);
    chk("rst.err",   32'(mem_err),  32'h0);
    chk("rst.stall", 32'(mem_stall), 32'h0);
    chk("rst.wbalu", wb_aluR,       32'h0);
    chk("rst.wbdst", 32'(wb_destR), 32'h0);
    chk_bubble("rst");
    #10 rst = 1'b1;
    tick();

    // Single-cycle table
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].i);
      dmem_ack = 1'b0;
      #4;
      chk("tbl.stall",  32'(mem_stall), 32'h0);
      chk("tbl.pcsrc",  32'(mem_pcsrc), 32'(tbl[i].e_pcsrc));
      chk("tbl.target", mem_target,     tbl[i].e_target);
      chk("tbl.req",    32'(dmem_req),  32'h0);
      tick();
      chk("tbl.err",    32'(mem_err),   32'(tbl[i].e_err));
      chk("tbl.wreg",   32'(wb_wreg),   32'(tbl[i].e_wreg));
      chk("tbl.m2reg",  32'(wb_m2reg),  32'(tbl[i].e_m2reg));
      chk("tbl.tags",   32'({MEM_ins_type, MEM_ins_number}), 32'({tbl[i].e_ty, tbl[i].e_nu}));
      chk("tbl.mdata",  wb_mdata,       exp_mdata);
      if (tbl[i].chk_alu) begin
        chk("tbl.alu",  wb_aluR,        tbl[i].e_alu);
        chk("tbl.dest", 32'(wb_destR),  32'(tbl[i].e_dest));
      end
    end
    run_single("err_end", nop, 1'b0);

    // Load at 0x40 acked on the third WAIT cycle, then store acked at once
    run_access("load40", mk(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 1'b0, 32'h0, 4'h2, 4'h1),
               3, 32'hDEADBEEF, 1'b0);
    run_access("store80", mk(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, 4'h3, 4'h1),
               1, 32'h0BADF00D, 1'b0);

    // Reset while waiting: request abandoned, no write-back
    drive(mk(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd9, 1'b0, 32'h0, 4'h4, 4'h4));
    #4;
    tick();
    chk("mrst.req_before", 32'(dmem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    exp_mdata = 32'h0;
    chk("mrst.req",   32'(dmem_req), 32'h0);
    chk("mrst.we",    32'(dmem_we),  32'h0);
    chk("mrst.addr",  dmem_addr,     32'h0);
    chk("mrst.err",   32'(mem_err),  32'h0);
    chk("mrst.wbalu", wb_aluR,       32'h0);
    chk_bubble("mrst");
    rst = 1'b1;
    run_single("mrst.after", nop, 1'b0);

    // Missing ack
    x = mk(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, 1'b0, 32'h0, 4'h5, 4'h5);
`ifdef MEM_STAGE_TIMEOUT_EN
    drive(x);
    #4;
    chk("tmo.stall0", 32'(mem_stall), 32'h1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      #4;
      chk("tmo.stall", 32'(mem_stall), 32'(k < 4));
      tick();
      chk("tmo.req", 32'(dmem_req), 32'(k < 4));
      chk("tmo.err", 32'(mem_err),  32'(k == 4));
      chk_bubble("tmo");
    end
    run_single("tmo.after", nop, 1'b0);
`else
    run_access("noack", x, 120, 32'h5555AAAA, 1'b0);
`endif

    // Randomised instruction stream against the transaction model
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if (kind == 0) begin
        x = mk(1'($urandom), 1'b0, 1'b0, a, $urandom, 5'($urandom), 1'($urandom),
               $urandom, 4'($urandom), 4'($urandom));
        run_single("rnd.alu", x, 1'($urandom));
      end else if (kind == 1) begin
        a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0)
          x = mk(1'b1, 1'b1, 1'b0, a, $urandom, 5'($urandom), 1'b0, $urandom,
                 4'($urandom), 4'($urandom));
        else
          x = mk(1'b0, 1'b0, 1'b1, a, $urandom, 5'($urandom), 1'b0, $urandom,
                 4'($urandom), 4'($urandom));
        run_single("rnd.mis", x, 1'($urandom));
      end else begin
        a[1:0] = 2'b00;
        if (kind == 2)
          x = mk(1'b1, 1'b1, 1'b0, a, $urandom, 5'($urandom), 1'b0, $urandom,
                 4'($urandom), 4'($urandom));
        else
          x = mk(1'b0, 1'b0, 1'b1, a, $urandom, 5'($urandom), 1'b0, $urandom,
                 4'($urandom), 4'($urandom));
        run_access("rnd.acc", x, $urandom_range(1, 4), $urandom, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
